// File: rtl/pe_bram_pkg.sv
// Shared constants for the PE BRAM responder: run-FSM encoding, byte enables, default sizes.
package pe_bram_pkg;

    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned STATE_W    = 2;

    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_START = 2'd1;
    localparam logic [STATE_W-1:0] S_RUN   = 2'd2;
    localparam logic [STATE_W-1:0] S_FIN   = 2'd3;

    localparam logic [BE_W-1:0] BYTE_EN_FULL = 4'hF;

endpackage

// File: rtl/pe_bram_responder_bram.sv
// Single-port byte-enable block RAM with registered, read-first output.
module bram_sp_be #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read old word and apply enabled byte lanes in the same access.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int b = 0; b < NB; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/pe_bram_responder.sv
// Memory-side responder for pe_con: host load/readback in IDLE, PE BRAM port while a run is active.
module pe_bram_responder
    import pe_bram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       BRAM_ADDR,
    input  logic [31:0]       BRAM_WRDATA,
    input  logic [3:0]        BRAM_WE,
    output logic [31:0]       BRAM_RDDATA,
    output logic              pe_start,
    input  logic              pe_done,
    input  logic              host_cmd_valid,
    output logic              host_cmd_ready,
    input  logic              host_cmd_we,
    input  logic [ADDR_W-1:0] host_cmd_addr,
    input  logic [31:0]       host_cmd_wdata,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,
    input  logic              host_go,
    output logic              busy,
    output logic              irq,
    output logic              addr_err
);

    logic [STATE_W-1:0] state, state_nx;
    logic               go_pending, go_pending_nx;
    logic               addr_err_nx;
    logic               pe_start_nx, busy_nx, irq_nx, ready_nx;

    logic               pe_side, pe_oor, go_accept, host_xfer;
    logic [ADDR_W-1:0]  pe_idx;

    logic               ram_en;
    logic [BE_W-1:0]    ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [31:0]        ram_wdata, ram_rdata;

    logic               pe_rd_q, oor_q;
    logic [31:0]        pe_hold, host_hold;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^BRAM_ADDR[1:0];

    assign pe_side   = (state != S_IDLE);
    assign pe_oor    = |BRAM_ADDR[31:ADDR_W+2];
    assign pe_idx    = BRAM_ADDR[ADDR_W+1:2];
    assign go_accept = (state == S_IDLE) && host_go;
    assign host_xfer = host_cmd_valid && host_cmd_ready;

    // Next state, pending go, sticky error and the registered-output next values.
    always_comb begin
        state_nx      = state;
        go_pending_nx = go_pending;
        addr_err_nx   = addr_err;
        case (state)
            S_IDLE:  if (host_go || go_pending) state_nx = S_START;
            S_START: state_nx = S_RUN;
            S_RUN:   if (pe_done) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (go_accept) begin
            go_pending_nx = 1'b1;
        end else if (state == S_START) begin
            go_pending_nx = 1'b0;
        end
        if (go_accept) begin
            addr_err_nx = 1'b0;
        end else if (pe_side && pe_oor) begin
            addr_err_nx = 1'b1;
        end
        pe_start_nx = (state_nx == S_START);
        busy_nx     = (state_nx != S_IDLE);
        irq_nx      = (state_nx == S_FIN);
        ready_nx    = (state_nx == S_IDLE) && !go_pending_nx;
    end

    // State and control registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= S_IDLE;
            go_pending     <= 1'b0;
            addr_err       <= 1'b0;
            pe_start       <= 1'b0;
            busy           <= 1'b0;
            irq            <= 1'b0;
            host_cmd_ready <= 1'b0;
            host_rvalid    <= 1'b0;
            pe_rd_q        <= 1'b0;
            oor_q          <= 1'b0;
            pe_hold        <= 32'h0;
            host_hold      <= 32'h0;
        end else begin
            state          <= state_nx;
            go_pending     <= go_pending_nx;
            addr_err       <= addr_err_nx;
            pe_start       <= pe_start_nx;
            busy           <= busy_nx;
            irq            <= irq_nx;
            host_cmd_ready <= ready_nx;
            host_rvalid    <= host_xfer && !host_cmd_we;
            pe_rd_q        <= pe_side;
            oor_q          <= pe_side && pe_oor;
            pe_hold        <= BRAM_RDDATA;
            host_hold      <= host_rdata;
        end
    end

    // Single memory port: state selects PE or host as the owner.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = host_cmd_addr;
        ram_wdata = host_cmd_wdata;
        if (pe_side) begin
            ram_en    = 1'b1;
            ram_we    = pe_oor ? 4'h0 : BRAM_WE;
            ram_addr  = pe_idx;
            ram_wdata = BRAM_WRDATA;
        end else if (host_xfer) begin
            ram_en = 1'b1;
            ram_we = host_cmd_we ? BYTE_EN_FULL : 4'h0;
        end
    end

    bram_sp_be #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (aclk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Read data fan-out: fresh RAM word on the cycle after an access, held value otherwise.
    assign BRAM_RDDATA = pe_rd_q ? (oor_q ? 32'h0 : ram_rdata) : pe_hold;
    assign host_rdata  = host_rvalid ? ram_rdata : host_hold;

endmodule

// File: tb/tb_pe_bram_responder.sv
// Scoreboard bench for pe_bram_responder with a word-array memory model.
module tb_pe_bram_responder;

    localparam int unsigned AW    = 13;
    localparam int unsigned DEPTH = 1 << AW;

    logic          aclk, aresetn;
    logic [31:0]   BRAM_ADDR, BRAM_WRDATA, BRAM_RDDATA;
    logic [3:0]    BRAM_WE;
    logic          pe_start, pe_done;
    logic          host_cmd_valid, host_cmd_ready, host_cmd_we;
    logic [AW-1:0] host_cmd_addr;
    logic [31:0]   host_cmd_wdata, host_rdata;
    logic          host_rvalid, host_go, busy, irq, addr_err;

    pe_bram_responder #(.ADDR_W(AW)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .BRAM_ADDR      (BRAM_ADDR),
        .BRAM_WRDATA    (BRAM_WRDATA),
        .BRAM_WE        (BRAM_WE),
        .BRAM_RDDATA    (BRAM_RDDATA),
        .pe_start       (pe_start),
        .pe_done        (pe_done),
        .host_cmd_valid (host_cmd_valid),
        .host_cmd_ready (host_cmd_ready),
        .host_cmd_we    (host_cmd_we),
        .host_cmd_addr  (host_cmd_addr),
        .host_cmd_wdata (host_cmd_wdata),
        .host_rvalid    (host_rvalid),
        .host_rdata     (host_rdata),
        .host_go        (host_go),
        .busy           (busy),
        .irq            (irq),
        .addr_err       (addr_err)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          pe_tag = 0;
    bit          pe_chk = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] host_q [$];
    int          host_cyc_q [$];
    logic [31:0] pe_q [$];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Cycle counter and one-cycle delayed PE read tag.
    always @(posedge aclk) begin
        cyc    <= cyc + 1;
        pe_chk <= pe_tag;
    end

    // Monitor: pop expected values whenever the DUT presents read data.
    always @(negedge aclk) begin : mon
        logic [31:0] e;
        int          c;
        if (host_rvalid) begin
            if (host_q.size() == 0) begin
                check("host_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e = host_q.pop_front();
                c = host_cyc_q.pop_front();
                check("host_rdata", host_rdata, e);
                check("host_rd_latency", cyc, c);
            end
        end
        if (pe_chk) begin
            if (pe_q.size() == 0) begin
                check("pe_read_unexpected", 32'd1, 32'd0);
            end else begin
                check("pe_rddata", BRAM_RDDATA, pe_q.pop_front());
            end
        end
    end

    // Host command; called and returns just after a rising edge.
    task automatic host_cmd(input bit we, input logic [AW-1:0] a, input logic [31:0] d);
        int n;
        bit done;
        n = 0;
        done = 0;
        host_cmd_valid = 1'b1;
        host_cmd_we    = we;
        host_cmd_addr  = a;
        host_cmd_wdata = d;
        while (!done) begin
            @(negedge aclk);
            if (host_cmd_ready) begin
                check("accept_while_idle", busy, 32'd0);
                if (we) begin
                    model[a] = d;
                end else begin
                    host_q.push_back(model[a]);
                    host_cyc_q.push_back(cyc + 1);
                end
                done = 1;
            end else if (++n > 2000) begin
                check("host_ready_timeout", 32'd0, 32'd1);
                done = 1;
            end
            @(posedge aclk); #1;
        end
        host_cmd_valid = 1'b0;
    endtask

    // One PE-side access cycle; expected read data is the pre-write word, 0 when out of range.
    task automatic pe_access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d, input bit chk);
        logic [AW-1:0] idx;
        bit            oor;
        idx = a[AW+1:2];
        oor = (a[31:AW+2] != 0);
        BRAM_ADDR   = a;
        BRAM_WE     = we;
        BRAM_WRDATA = d;
        pe_tag      = chk;
        if (chk) pe_q.push_back(oor ? 32'h0 : model[idx]);
        if (!oor) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            end
        end
        @(posedge aclk); #1;
        BRAM_WE   = 4'h0;
        BRAM_ADDR = 32'h0;
        pe_tag    = 1'b0;
    endtask

    // Pulse host_go from IDLE and check the start sequence; returns with the FSM in RUN.
    task automatic start_run();
        host_go = 1'b1;
        @(posedge aclk); #1;
        host_go = 1'b0;
        @(negedge aclk);
        check("start_pulse", pe_start, 32'd1);
        check("start_busy", busy, 32'd1);
        check("start_ready", host_cmd_ready, 32'd0);
        check("start_err_clear", addr_err, 32'd0);
        @(negedge aclk);
        check("start_one_cycle", pe_start, 32'd0);
        check("run_busy", busy, 32'd1);
        @(posedge aclk); #1;
    endtask

    // Raise done and check the irq/busy tail.
    task automatic finish_run();
        int n;
        n = 0;
        pe_done = 1'b1;
        @(negedge aclk);
        while (!irq && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("irq_seen", irq, 32'd1);
        check("busy_at_irq", busy, 32'd1);
        @(negedge aclk);
        check("irq_width", irq, 32'd0);
        check("busy_after_irq", busy, 32'd0);
        check("ready_after_irq", host_cmd_ready, 32'd1);
        @(posedge aclk); #1;
        pe_done = 1'b0;
    endtask

    logic [31:0] hold_val;
    int          t0;

    initial begin
        aresetn = 1'b0;
        BRAM_ADDR = 32'h0; BRAM_WRDATA = 32'h0; BRAM_WE = 4'h0;
        pe_done = 1'b0; host_go = 1'b0;
        host_cmd_valid = 1'b0; host_cmd_we = 1'b0; host_cmd_addr = '0; host_cmd_wdata = 32'h0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_bram_rddata", BRAM_RDDATA, 32'h0);
        check("rst_pe_start", pe_start, 32'd0);
        check("rst_ready", host_cmd_ready, 32'd0);
        check("rst_rvalid", host_rvalid, 32'd0);
        check("rst_rdata", host_rdata, 32'h0);
        check("rst_busy", busy, 32'd0);
        check("rst_irq", irq, 32'd0);
        check("rst_addr_err", addr_err, 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Load the whole memory so every word is known to the model.
        for (int i = 0; i < DEPTH; i++) host_cmd(1'b1, AW'(i), $urandom);
        host_cmd(1'b1, AW'(5), 32'hDEADBEEF);
        host_cmd(1'b0, AW'(5), 32'h0);
        for (int i = 0; i < 300; i++) host_cmd(1'($urandom), AW'($urandom), $urandom);
        host_cmd(1'b1, AW'(5), 32'hAAAAAAAA);
        host_cmd(1'b1, AW'(7), 32'h00000001);

        // Run 1: PE traffic, stalled host commands, go while busy, out-of-range access.
        t0 = cyc;
        start_run();
        fork
            begin
                host_cmd(1'b1, AW'(100), 32'hCAFE0001);
                host_cmd(1'b0, AW'(100), 32'h0);
            end
            begin
                pe_access(32'h14, 4'b0011, 32'h12345678, 1'b0);
                pe_access(32'h14, 4'b0000, 32'h0, 1'b1);
                pe_access(32'h1C, 4'b1111, 32'h00000002, 1'b1);
                pe_access(32'h1C, 4'b0000, 32'h0, 1'b1);
                pe_access(32'h0001_0000, 4'b1111, $urandom, 1'b1);
                for (int i = 0; i < 10; i++) begin
                    pe_access((32'($urandom_range(16, 63)) << 2) | 32'($urandom_range(0, 3)),
                              4'($urandom), $urandom, 1'b1);
                end
                host_go = 1'b1;
                @(posedge aclk); #1;
                host_go = 1'b0;
                while (cyc < t0 + 100) begin
                    @(negedge aclk);
                    check("run_ready_low", host_cmd_ready, 32'd0);
                end
                @(posedge aclk); #1;
                finish_run();
            end
        join
        check("addr_err_sticky", addr_err, 32'd1);
        hold_val = model[0];
        repeat (2) @(negedge aclk);
        check("go_ignored_busy", busy, 32'd0);
        check("go_ignored_start", pe_start, 32'd0);
        check("rddata_hold_idle", BRAM_RDDATA, hold_val);
        @(posedge aclk); #1;
        host_cmd(1'b0, AW'(7), 32'h0);
        @(negedge aclk);
        check("rddata_hold_host", BRAM_RDDATA, hold_val);
        check("addr_err_held", addr_err, 32'd1);
        @(posedge aclk); #1;

        // Go together with a host read; done already high when RUN is entered.
        host_go = 1'b1;
        host_cmd_valid = 1'b1; host_cmd_we = 1'b0; host_cmd_addr = AW'(5);
        @(negedge aclk);
        check("go_cmd_ready", host_cmd_ready, 32'd1);
        host_q.push_back(model[5]);
        host_cyc_q.push_back(cyc + 1);
        @(posedge aclk); #1;
        host_go = 1'b0; host_cmd_valid = 1'b0; pe_done = 1'b1;
        @(negedge aclk);
        check("go_cmd_start", pe_start, 32'd1);
        check("go_cmd_err_clear", addr_err, 32'd0);
        @(negedge aclk);
        check("early_done_run", irq, 32'd0);
        check("early_done_busy", busy, 32'd1);
        @(negedge aclk);
        check("early_done_irq", irq, 32'd1);
        @(negedge aclk);
        check("early_done_idle", busy, 32'd0);
        @(posedge aclk); #1;
        pe_done = 1'b0;

        // Reset in the middle of a run.
        start_run();
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        check("midrst_busy", busy, 32'd0);
        check("midrst_pe_start", pe_start, 32'd0);
        check("midrst_irq", irq, 32'd0);
        check("midrst_ready", host_cmd_ready, 32'd0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("postrst_idle", busy, 32'd0);
        @(posedge aclk); #1;

        // Full readback: out-of-range write dropped, memory intact across reset.
        for (int i = 0; i < DEPTH; i++) host_cmd(1'b0, AW'(i), 32'h0);
        repeat (5) @(negedge aclk);
        check("host_q_drained", host_q.size(), 32'd0);
        check("pe_q_drained", pe_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
